// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle FSM and the datapath/memory.
// master: controller (drives selects/enables), slave: datapath side.
interface mc_controller_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       retire;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
        output IRWrite, PCWrite, RegWrite, MemWrite,
        output retire, illegal_op, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
        input  IRWrite, PCWrite, RegWrite, MemWrite,
        input  retire, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM (lw/sw/R/I/beq/jal) with memory-ready waits.
// Ports: clk, reset_n (async low), bus (mc_controller_if.master): op/zero/mem_ready in, selects/enables out.
module mc_controller #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    mc_controller_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e state_q, state_d;
    logic   rdy;

    logic [1:0] alu_op, src_a, src_b, res_src, imm_src;
    logic       adr_src, ir_write, reg_write, mem_write;
    logic       retire_o, illegal_o, pc_update, branch;

    // Single-cycle memory build: waits collapse away.
    assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op    = 2'b00;
        src_a     = 2'b00;
        src_b     = 2'b00;
        res_src   = 2'b00;
        adr_src   = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        retire_o  = 1'b0;
        illegal_o = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                src_b     = 2'b10;
                res_src   = 2'b10;
                ir_write  = rdy;
                pc_update = rdy;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_o = 1'b0;
                    default:                                  illegal_o = 1'b1;
                endcase
            end
            S_MEMADR: begin
                src_a = 2'b10;
                src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                res_src   = 2'b01;
                reg_write = 1'b1;
                retire_o  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire_o  = rdy;
            end
            S_EXECR: begin
                src_a  = 2'b10;
                alu_op = 2'b10;
            end
            S_EXECI: begin
                src_a  = 2'b10;
                src_b  = 2'b01;
                alu_op = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire_o  = 1'b1;
            end
            S_BEQ: begin
                src_a    = 2'b10;
                alu_op   = 2'b01;
                branch   = 1'b1;
                retire_o = 1'b1;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign bus.ALUOp      = alu_op;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ResultSrc  = res_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.AdrSrc     = adr_src;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_update | (branch & bus.zero);
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.retire     = retire_o;
    assign bus.illegal_op = illegal_o;
    assign bus.state_dbg  = state_q;

endmodule
